if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the system reset; asynchronous, active-high.
REQ-004 The block SHALL have port id_stall, input, 1, the hazard-unit stall; when high, the IF/ID register holds.
REQ-005 The block SHALL have port ex_take_branch, input, 1, the redirect request: a taken branch or jump.
REQ-006 The block SHALL have port ex_target_PC, input, 32, the redirect target address.
REQ-007 The block SHALL have port imem_req, output, 1, the instruction fetch request.
REQ-008 The block SHALL have port imem_addr, output, 32, the fetch address; word aligned.
REQ-009 The block SHALL have port imem_gnt, input, 1, which accepts a request when high in the same cycle as imem_req.
REQ-010 The block SHALL have port imem_rvalid, input, 1, the response valid; responses return in order, at least one cycle after grant.
REQ-011 The block SHALL have port imem_rdata, input, 32, the response instruction word.
REQ-012 The block SHALL have port if_id_IR, output, 32, the registered instruction presented to decode.
REQ-013 The block SHALL have port if_id_PC, output, 32, the registered PC of if_id_IR.
REQ-014 The block SHALL have port if_id_valid, output, 1, which when high marks if_id_IR as a real fetched instruction.

Function
REQ-015 The block SHALL hold a fetch PC register; imem_addr equals the fetch PC.
REQ-016 The fetch PC SHALL advance by 4 on each cycle with imem_req & imem_gnt; arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-017 The block SHALL count credits as granted-not-returned requests plus fetch-buffer occupancy.
REQ-018 The block SHALL assert imem_req only while credits < 2, and never while rst is high.
REQ-019 The block SHALL record the fetch PC of each granted request in an in-order PC queue, depth 2, for pairing with its response.
REQ-020 The block SHALL contain a 2-entry fetch buffer holding {instruction, PC} pairs from accepted responses.
REQ-021 On a cycle with !id_stall, the IF/ID register SHALL load the buffer head, setting if_id_valid=1, and pop the buffer.
REQ-022 If the buffer is empty on that cycle, the IF/ID register SHALL instead bypass-load a same-cycle non-dropped response.
REQ-023 If neither source is available on that cycle, the IF/ID register SHALL load NOOP_INST (32'h0000_0013) with if_id_valid=0.
REQ-024 On a cycle with id_stall and no redirect, the IF/ID register SHALL hold, and responses SHALL enqueue into the buffer.
REQ-025 Buffer overflow SHALL be impossible by credit rule; the bench SHALL assert this.
REQ-026 Minimum latency SHALL be: grant in cycle T, rvalid in T+1, and if_id_IR valid from the edge ending T+1.
REQ-027 On ex_take_branch, at the next edge, the fetch PC SHALL load ex_target_PC and the buffer SHALL clear.
REQ-028 On ex_take_branch, at the next edge, the IF/ID register SHALL load NOOP_INST with if_id_valid=0, overriding id_stall.
REQ-029 On ex_take_branch, at the next edge, a drop counter SHALL load the number of in-flight requests, including one granted in the same cycle.
REQ-030 The block SHALL discard responses while the drop counter is nonzero, decrementing it once per response; discarded responses never reach the buffer or IF/ID.
REQ-031 When a redirect coincides with a grant, the redirect SHALL win: the granted word is dropped and the PC takes the target, not the target+4.
REQ-032 On a redirect cycle, the block SHALL not issue a new request; fetch resumes the following cycle at the target once credits allow.

Reset
REQ-033 While rst is high, the block SHALL set: fetch PC=RESET_PC, buffer empty, PC queue empty, drop counter 0, imem_req=0.
REQ-034 While rst is high, the block SHALL set: if_id_IR=NOOP_INST, if_id_PC=0, if_id_valid=0.
REQ-035 Reset mid-transaction SHALL abandon outstanding requests; the memory model is reset together with the block.

Structure
REQ-036 NOOP_INST, the default RESET_PC value and the credit depth constant (2) SHALL reside in the shared sys_defs package.
REQ-037 The buffer SHALL be a sub-module fetch_fifo: 2-entry, 64-bit wide, push/pop/flush, full/empty flags, and same-cycle push+pop supported when non-empty.

Verification
REQ-038 Scenario: reset release, zero-wait memory -> imem_addr 0,4,8…; if_id_PC 0,4,8 on consecutive cycles with if_id_valid=1.
REQ-039 Scenario: id_stall high for 3 cycles at PC 8 -> if_id_PC stays 8, imem_req drops when credits reach 2, no instruction is lost or duplicated afterwards.
REQ-040 Scenario: ex_take_branch to 32'h100 with 2 requests in flight -> both responses discarded, then 1 NOP bubble, then if_id_PC=32'h100.
REQ-041 Scenario: redirect to 32'h40 in the same cycle as a grant at 32'h0C -> the 0x0C word never appears, and the next imem_addr is 32'h40.
REQ-042 Scenario: random gnt/rvalid delays of 0-4 cycles over 200 instructions -> the if_id_PC sequence matches the reference PC stream exactly.
REQ-043 Scenario: fetch at 32'hFFFF_FFFC -> the next imem_addr is 32'h0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and the fetch buffer entry type.
package sys_defs;

  localparam logic [31:0] NOOP_INST        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IF_CREDITS       = 2;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus between fetch stage and memory.
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/if_stage_fifo.sv
// Two-entry {instruction, PC} fetch buffer with flush; push+pop allowed together.
module fetch_fifo
  import sys_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited requests, in-order PC pairing,
// redirect with response dropping, and the IF/ID pipeline register.
module if_stage
  import sys_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall,
  input  logic              ex_take_branch,
  input  logic [31:0]       ex_target_PC,
  if_stage_if.master        imem,
  output logic [31:0]       if_id_IR,
  output logic [31:0]       if_id_PC,
  output logic              if_id_valid
);

  logic [31:0]  r_pc;
  logic [1:0]   r_out;
  logic [1:0]   r_drop;
  logic [31:0]  r_pcq [2];

  logic         w_ff_full;
  logic         w_ff_empty;
  fetch_entry_t w_ff_head;
  fetch_entry_t w_rsp;
  logic [1:0]   w_ff_cnt;
  logic [2:0]   w_credits;
  logic         w_fire;
  logic         w_rsp_ok;
  logic         w_load_head;
  logic         w_bypass;
  logic         w_ff_push;
  logic [1:0]   w_out_next;
  logic         w_pcq_wr;

  assign w_ff_cnt  = w_ff_full ? 2'd2 : (w_ff_empty ? 2'd0 : 2'd1);
  assign w_credits = {1'b0, r_out} + {1'b0, w_ff_cnt};

  assign imem.imem_req  = !rst && !ex_take_branch && (w_credits < 3'(IF_CREDITS));
  assign imem.imem_addr = r_pc;

  assign w_fire     = imem.imem_req && imem.imem_gnt;
  assign w_out_next = r_out + {1'b0, w_fire} - {1'b0, imem.imem_rvalid};

  // A response on the redirect cycle is stale as well, so it never counts as usable.
  assign w_rsp_ok    = imem.imem_rvalid && (r_drop == 2'd0) && !ex_take_branch;
  assign w_rsp       = {imem.imem_rdata, r_pcq[0]};
  assign w_load_head = !ex_take_branch && !id_stall && !w_ff_empty;
  assign w_bypass    = !ex_take_branch && !id_stall && w_ff_empty && w_rsp_ok;
  assign w_ff_push   = w_rsp_ok && !w_bypass;

  assign w_pcq_wr = (r_out == 2'd1) && !imem.imem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= w_out_next;
      if (ex_take_branch) begin
        r_pc   <= ex_target_PC;
        r_drop <= w_out_next;
      end else begin
        if (w_fire) r_pc <= r_pc + 32'd4;
        if (imem.imem_rvalid && (r_drop != 2'd0)) r_drop <= r_drop - 2'd1;
      end
    end
  end

  // Every response pops the PC queue, dropped or not, so pairing stays in order.
  always_ff @(posedge clk) begin
    if (imem.imem_rvalid) r_pcq[0] <= r_pcq[1];
    if (w_fire)           r_pcq[w_pcq_wr] <= r_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_IR    <= NOOP_INST;
      if_id_PC    <= '0;
      if_id_valid <= 1'b0;
    end else if (ex_take_branch) begin
      if_id_IR    <= NOOP_INST;
      if_id_PC    <= '0;
      if_id_valid <= 1'b0;
    end else if (!id_stall) begin
      if (w_load_head) begin
        if_id_IR    <= w_ff_head.ir;
        if_id_PC    <= w_ff_head.pc;
        if_id_valid <= 1'b1;
      end else if (w_bypass) begin
        if_id_IR    <= w_rsp.ir;
        if_id_PC    <= w_rsp.pc;
        if_id_valid <= 1'b1;
      end else begin
        if_id_IR    <= NOOP_INST;
        if_id_PC    <= '0;
        if_id_valid <= 1'b0;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ff_push),
    .i_pop   (w_load_head),
    .i_flush (ex_take_branch),
    .i_wdata (w_rsp),
    .o_rdata (w_ff_head),
    .o_full  (w_ff_full),
    .o_empty (w_ff_empty)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reactive memory model, expected-PC scoreboard, directed scenarios.
module tb_if_stage;
  import sys_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        ex_take_branch;
  logic [31:0] ex_target_PC;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid;

  if_stage_if imem_bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .id_stall       (id_stall),
    .ex_take_branch (ex_take_branch),
    .ex_target_PC   (ex_target_PC),
    .imem           (imem_bus),
    .if_id_IR       (if_id_IR),
    .if_id_PC       (if_id_PC),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_q [$];
  pend_t       pend_q [$];
  int          cyc = 0;
  int          gnt_wait = 0;
  int          gnt_count = 0;
  int          mem_delay = 0;
  bit          gnt_rand = 1'b0;
  logic [31:0] last_gnt_addr = '0;
  int          ovf_events = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: drive gnt/rvalid at negedge, commit the handshake 2 time units later.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend_q.delete();
      gnt_wait = 0;
    end
    if (gnt_wait > 0) begin
      imem_bus.imem_gnt = 1'b0;
      gnt_wait--;
    end else begin
      imem_bus.imem_gnt = 1'b1;
    end
    if (!rst && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = word_of(pend_q[0].addr);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
    end
    #2;
    if (!rst) begin
      if (imem_bus.imem_rvalid) void'(pend_q.pop_front());
      if (imem_bus.imem_req && imem_bus.imem_gnt) begin
        pend_q.push_back(pend_t'{addr: imem_bus.imem_addr,
                                 ready: cyc + 1 + (gnt_rand ? int'($urandom_range(0, 4)) : mem_delay)});
        gnt_count++;
        last_gnt_addr = imem_bus.imem_addr;
        gnt_wait = gnt_rand ? int'($urandom_range(0, 4)) : 0;
      end
    end
  end

  // Decode consumes IF/ID at the coming edge when valid, not stalled, not squashed.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    #3;
    if (!rst && if_id_valid && !id_stall && !ex_take_branch) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_instr", if_id_PC, 32'hFFFF_FFFF);
      end else begin
        exp_pc = sb_q.pop_front();
        chk("if_id_PC", if_id_PC, exp_pc);
        chk("if_id_IR", if_id_IR, word_of(exp_pc));
      end
    end
    if (!rst && u_dut.u_fifo.i_push && u_dut.u_fifo.o_full && !u_dut.u_fifo.i_pop)
      ovf_events++;
  end

  task automatic push_seg(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(base + 32'(4 * i));
  endtask

  task automatic redirect(input logic [31:0] tgt, input int n);
    ex_take_branch = 1'b1;
    ex_target_PC   = tgt;
    id_stall       = 1'b0;
    sb_q.delete();
    push_seg(tgt, n);
    @(negedge clk);
    ex_take_branch = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc, input bit rnd_stall);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (rnd_stall) id_stall = ($urandom_range(0, 3) == 0);
    end
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    id_stall = 1'b0;
    ex_take_branch = 1'b0;
    ex_target_PC = '0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst_addr", imem_bus.imem_addr, 32'h0);
    chk("rst_IR", if_id_IR, NOOP_INST);
    chk("rst_PC", if_id_PC, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);

    // Zero-wait stream from reset, with a 3-cycle stall while PC 8 is in IF/ID.
    push_seg(32'h0, 8);
    @(negedge clk); rst = 1'b0;
    #1 chk("addr_c0", imem_bus.imem_addr, 32'h0);
    @(negedge clk); #1 chk("addr_c1", imem_bus.imem_addr, 32'h4);
    @(negedge clk); #1 chk("addr_c2", imem_bus.imem_addr, 32'h8);
    chk("ifid_c2_pc", if_id_PC, 32'h0);
    chk("ifid_c2_valid", 32'(if_id_valid), 32'd1);
    @(negedge clk); #1 chk("ifid_c3_pc", if_id_PC, 32'h4);
    @(negedge clk); id_stall = 1'b1;
    #1 chk("stall0_pc", if_id_PC, 32'h8);
    chk("stall0_valid", 32'(if_id_valid), 32'd1);
    @(negedge clk); #1 chk("stall1_pc", if_id_PC, 32'h8);
    @(negedge clk); #1 chk("stall2_pc", if_id_PC, 32'h8);
    chk("stall2_req_off", 32'(imem_bus.imem_req), 32'd0);
    @(negedge clk); id_stall = 1'b0;
    drain("drain_seq0", 200, 1'b0);

    // Long-latency memory so two requests are in flight at the redirect.
    mem_delay = 3;
    redirect(32'h200, 16);
    repeat (6) @(negedge clk);
    n = 0;
    while (pend_q.size() != 2 && n < 100) begin @(negedge clk); n++; end
    chk("inflight_two", 32'(pend_q.size()), 32'd2);
    mem_delay = 0;
    redirect(32'h100, 4);
    #1 chk("redirect_bubble", 32'(if_id_valid), 32'd0);
    n = 0;
    while (!if_id_valid && n < 100) begin @(negedge clk); #1; n++; end
    chk("first_after_redirect", if_id_PC, 32'h100);
    drain("drain_100", 200, 1'b0);

    // Redirect to 0x40 in the cycle the DUT would request 0x0C.
    redirect(32'h0, 3);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(imem_bus.imem_addr == 32'h0C && imem_bus.imem_req) && n < 100);
    chk("reach_0C", imem_bus.imem_addr, 32'h0C);
    n = gnt_count;
    redirect(32'h40, 3);
    for (int k = 0; k < 100 && gnt_count == n; k++) @(negedge clk);
    chk("gnt_after_0C", last_gnt_addr, 32'h40);
    drain("drain_40", 200, 1'b0);

    // Address wrap at the top of memory.
    redirect(32'hFFFF_FFF0, 8);
    n = 0;
    while (imem_bus.imem_addr != 32'hFFFF_FFFC && n < 100) begin @(negedge clk); #1; n++; end
    n = 0;
    while (imem_bus.imem_addr == 32'hFFFF_FFFC && n < 100) begin @(negedge clk); #1; n++; end
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);
    drain("drain_wrap", 200, 1'b0);

    // Random grant/response delays and random stalls over 200 instructions.
    gnt_rand = 1'b1;
    redirect(32'h1000, 200);
    drain("drain_random", 8000, 1'b1);
    id_stall = 1'b1;
    gnt_rand = 1'b0;
    repeat (3) @(negedge clk);

    // Reset asserted with traffic outstanding.
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("midrst_IR", if_id_IR, NOOP_INST);
    chk("midrst_valid", 32'(if_id_valid), 32'd0);
    chk("midrst_addr", imem_bus.imem_addr, 32'h0);
    chk("fifo_overflow", 32'(ovf_events), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
